// File: rtl/alu_exec_unit.sv
// RV32I integer/branch execution unit: computes one result per accepted issue
// and queues it in a small in-order FIFO that drains onto the CDB under a
// request/grant handshake.
module alu_exec_unit #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                exe_valid,
  input  logic [6:0]          exe_opcode,
  input  logic [2:0]          exe_func3,
  input  logic                exe_func1,
  input  logic [DATA_W-1:0]   exe_data1,
  input  logic [DATA_W-1:0]   exe_data2,
  input  logic [DATA_W-1:0]   exe_imm,
  input  logic [DATA_W-1:0]   exe_off,
  input  logic [DATA_W-1:0]   exe_pc,
  input  logic [ROB_ID_W-1:0] exe_rob_target,
  output logic                alu_ready,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [ROB_ID_W-1:0] alu_rob_id,
  output logic [DATA_W-1:0]   alu_data,
  output logic                alu_jump,
  output logic [DATA_W-1:0]   alu_target_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] FOUR    = DATA_W'(4);
  localparam logic [DATA_W-1:0] ZERO    = '0;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Integer op selected by funct3; alt picks SUB (000) or arithmetic shift (101).
  function automatic logic [DATA_W-1:0] alu_op(input logic [2:0] f3,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic alt);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic signed [DATA_W-1:0] sra;
    logic [4:0]               sh;
    logic [DATA_W-1:0]        r;
    sa  = a;
    sb  = b;
    sh  = b[4:0];
    sra = sa >>> sh;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << sh;
      3'b010:  r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      3'b011:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  begin
        if (alt) r = sra;
        else     r = a >> sh;
      end
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Branch condition by funct3; reserved encodings never take.
  function automatic logic br_cond(input logic [2:0] f3,
                                   input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic                     c;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = (sa < sb);
      3'b101:  c = (sa >= sb);
      3'b110:  c = (a < b);
      3'b111:  c = (a >= b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [ROB_ID_W-1:0] rob_mem  [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic                jump_mem [DEPTH];
  logic [DATA_W-1:0]   tpc_mem  [DEPTH];

  logic [DATA_W-1:0] res_data_p0;
  logic              res_jump_p0;
  logic [DATA_W-1:0] res_tpc_p0;
  logic [DATA_W-1:0] pc_plus4_p0;
  logic [DATA_W-1:0] pc_off_p0;
  logic [DATA_W-1:0] jalr_sum_p0;
  logic              cond_p0;
  logic              push;
  logic              pop;

  assign pc_plus4_p0 = exe_pc + FOUR;
  assign pc_off_p0   = exe_pc + exe_off;
  assign jalr_sum_p0 = exe_data1 + exe_imm;
  assign cond_p0     = br_cond(exe_func3, exe_data1, exe_data2);

  // Stage p0: decode and compute the result straight from the issue inputs.
  always_comb begin
    res_data_p0 = ZERO;
    res_jump_p0 = 1'b0;
    res_tpc_p0  = pc_plus4_p0;
    case (exe_opcode)
      OP_LUI:    res_data_p0 = exe_imm;
      OP_AUIPC:  res_data_p0 = exe_pc + exe_imm;
      OP_IMM:    res_data_p0 = alu_op(exe_func3, exe_data1, exe_imm,
                                      exe_func1 && (exe_func3 == 3'b101));
      OP_REG:    res_data_p0 = alu_op(exe_func3, exe_data1, exe_data2, exe_func1);
      OP_JAL: begin
        res_data_p0 = pc_plus4_p0;
        res_jump_p0 = 1'b1;
        res_tpc_p0  = pc_off_p0;
      end
      OP_JALR: begin
        res_data_p0 = pc_plus4_p0;
        res_jump_p0 = 1'b1;
        res_tpc_p0  = {jalr_sum_p0[DATA_W-1:1], 1'b0};
      end
      OP_BRANCH: begin
        res_jump_p0 = cond_p0;
        res_tpc_p0  = cond_p0 ? pc_off_p0 : pc_plus4_p0;
      end
      default: ;
    endcase
  end

  // Ready is withheld during reset, rollback, stall, or when the FIFO is full.
  assign alu_ready = !rst && rdy && !rollback && (count < DEPTH_C);
  assign cdb_req   = (count != '0);
  assign push      = exe_valid && alu_ready;
  assign pop       = cdb_req && cdb_grant && rdy && !rollback;

  // FIFO control: pointers and occupancy; rollback flushes regardless of rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rollback) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: result storage, cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_mem[i]  <= '0;
        data_mem[i] <= '0;
        jump_mem[i] <= 1'b0;
        tpc_mem[i]  <= '0;
      end
    end else if (push) begin
      rob_mem[wr_ptr]  <= exe_rob_target;
      data_mem[wr_ptr] <= res_data_p0;
      jump_mem[wr_ptr] <= res_jump_p0;
      tpc_mem[wr_ptr]  <= res_tpc_p0;
    end
  end

  assign alu_rob_id    = rob_mem[rd_ptr];
  assign alu_data      = data_mem[rd_ptr];
  assign alu_jump      = jump_mem[rd_ptr];
  assign alu_target_pc = tpc_mem[rd_ptr];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected head results are queued as
// instructions are issued and compared as they appear on the CDB outputs.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] data;
    logic        jump;
    logic [31:0] tpc;
  } res_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f1;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] off;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jump;
    logic [31:0] tpc;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        exe_valid = 1'b0;
  logic [6:0]  exe_opcode = '0;
  logic [2:0]  exe_func3 = '0;
  logic        exe_func1 = 1'b0;
  logic [31:0] exe_data1 = '0;
  logic [31:0] exe_data2 = '0;
  logic [31:0] exe_imm = '0;
  logic [31:0] exe_off = '0;
  logic [31:0] exe_pc = '0;
  logic [3:0]  exe_rob_target = '0;
  logic        alu_ready;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_data;
  logic        alu_jump;
  logic [31:0] alu_target_pc;

  res_t  head_obs;
  res_t  sb[$];
  stim_t st[12];
  int    n_chk = 0;
  int    n_fail = 0;

  assign head_obs = {alu_rob_id, alu_data, alu_jump, alu_target_pc};

  alu_exec_unit #(.DATA_W(32), .ROB_ID_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_func3(exe_func3),
    .exe_func1(exe_func1), .exe_data1(exe_data1), .exe_data2(exe_data2),
    .exe_imm(exe_imm), .exe_off(exe_off), .exe_pc(exe_pc),
    .exe_rob_target(exe_rob_target), .alu_ready(alu_ready), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
    .alu_jump(alu_jump), .alu_target_pc(alu_target_pc)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk_add(input logic [3:0] tag, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] sum);
    stim_t s;
    s = '{OP_REG, 3'b000, 1'b0, a, b, 32'd0, 32'd0, 32'h40, tag, sum, 1'b0, 32'h44};
    return s;
  endfunction

  task automatic set_issue(input stim_t s);
    exe_opcode     = s.op;
    exe_func3      = s.f3;
    exe_func1      = s.f1;
    exe_data1      = s.d1;
    exe_data2      = s.d2;
    exe_imm        = s.imm;
    exe_off        = s.off;
    exe_pc         = s.pc;
    exe_rob_target = s.tag;
    exe_valid      = 1'b1;
  endtask

  task automatic push_exp(input stim_t s);
    res_t r;
    r.rob  = s.tag;
    r.data = s.data;
    r.jump = s.jump;
    r.tpc  = s.tpc;
    sb.push_back(r);
  endtask

  task automatic test_reset();
    n_chk++;
    if (cdb_req !== 1'b0 || head_obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b head=%h, expected req=0 head=0", cdb_req, head_obs);
    end
    n_chk++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", alu_ready);
    end
    set_issue(mk_add(4'd1, 32'd1, 32'd2, 32'd3));
    @(negedge clk);
    set_issue(mk_add(4'd2, 32'd3, 32'd4, 32'd7));
    @(negedge clk);
    exe_valid = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b1 || alu_ready !== 1'b0 || alu_rob_id !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_prefill: req=%b ready=%b tag=%0d expected 1 0 1", cdb_req, alu_ready, alu_rob_id);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (cdb_req !== 1'b0 || head_obs !== '0 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: req=%b ready=%b head=%h expected 0 0 0", cdb_req, alu_ready, head_obs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (alu_ready !== 1'b1 || cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b req=%b expected 1 0", alu_ready, cdb_req);
    end
  endtask

  task automatic test_alu_ops();
    int n;
    st[0] = mk_add(4'd3, 32'd5, 32'd7, 32'd12);
    st[1] = '{OP_REG, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 32'h40, 4'd4, 32'hFFFFFFFE, 1'b0, 32'h44};
    st[2] = '{OP_IMM, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h404, 32'd0, 32'h40, 4'd5, 32'hF8000000, 1'b0, 32'h44};
    st[3] = '{OP_IMM, 3'b101, 1'b0, 32'h80000000, 32'd0, 32'h4, 32'd0, 32'h40, 4'd6, 32'h08000000, 1'b0, 32'h44};
    st[4] = '{OP_REG, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h40, 4'd7, 32'd1, 1'b0, 32'h44};
    st[5] = '{OP_REG, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h40, 4'd8, 32'd0, 1'b0, 32'h44};
    st[6] = '{OP_REG, 3'b001, 1'b0, 32'd1, 32'd31, 32'd0, 32'd0, 32'h40, 4'd9, 32'h80000000, 1'b0, 32'h44};
    st[7] = '{OP_LUI, 3'b000, 1'b0, 32'd9, 32'd9, 32'h12345000, 32'd0, 32'h40, 4'd10, 32'h12345000, 1'b0, 32'h44};
    st[8] = '{OP_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'd0, 32'h40, 4'd11, 32'h1040, 1'b0, 32'h44};
    st[9] = '{OP_IMM, 3'b000, 1'b1, 32'd5, 32'd0, 32'h400, 32'd0, 32'h40, 4'd12, 32'h405, 1'b0, 32'h44};
    n = 10;
    cdb_grant = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        n_chk++;
        if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
          n_fail++;
          $display("FAIL alu_op_%0d: req=%b head=%h expected %h", i - 1, cdb_req, head_obs, sb[0]);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (i < n) begin
        set_issue(st[i]);
        push_exp(st[i]);
      end else begin
        exe_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_drain: req=%b expected 0", cdb_req);
    end
    cdb_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    cdb_grant = 1'b0;
    st[0] = mk_add(4'd6, 32'd1, 32'd1, 32'd2);
    st[1] = '{OP_REG, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'h40, 4'd7, 32'hFF, 1'b0, 32'h44};
    st[2] = mk_add(4'd8, 32'd9, 32'd9, 32'd18);
    st[3] = '{OP_REG, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 32'h40, 4'd9, 32'h0F, 1'b0, 32'h44};
    st[4] = '{OP_REG, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 32'h40, 4'd10, 32'hF0, 1'b0, 32'h44};
    for (int i = 0; i < 3; i++) begin
      set_issue(st[i]);
      #1;
      n_chk++;
      if (alu_ready !== (i < 2)) begin
        n_fail++;
        $display("FAIL bp_ready_%0d: got %b expected %b", i, alu_ready, (i < 2));
      end
      if (i < 2) push_exp(st[i]);
      @(negedge clk);
    end
    exe_valid = 1'b0;
    cdb_grant = 1'b1;
    n_chk++;
    if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
      n_fail++;
      $display("FAIL bp_pop1: req=%b head=%h expected %h", cdb_req, head_obs, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    n_chk++;
    if (alu_ready !== 1'b1 || sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
      n_fail++;
      $display("FAIL bp_pop2: ready=%b head=%h expected ready=1 head %h", alu_ready, head_obs, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    set_issue(st[3]);
    push_exp(st[3]);
    @(negedge clk);
    cdb_grant = 1'b0;
    set_issue(st[4]);
    #1;
    n_chk++;
    if (alu_ready !== 1'b1 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
      n_fail++;
      $display("FAIL bp_pushpop: ready=%b head=%h expected ready=1 head %h", alu_ready, head_obs, sb[0]);
    end
    push_exp(st[4]);
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_chk++;
    if (alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_after_pushpop: ready=%b expected 0", alu_ready);
    end
    cdb_grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: req=%b head=%h expected %h", i, cdb_req, head_obs, sb[0]);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge clk);
    end
    cdb_grant = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: req=%b expected 0", cdb_req);
    end
  endtask

  task automatic test_branches();
    int n;
    st[0] = '{OP_BRANCH, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h20, 32'h100, 4'd1, 32'd0, 1'b1, 32'h120};
    st[1] = '{OP_BRANCH, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h20, 32'h100, 4'd2, 32'd0, 1'b1, 32'h120};
    st[2] = '{OP_BRANCH, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h20, 32'h100, 4'd3, 32'd0, 1'b0, 32'h104};
    st[3] = '{OP_JALR, 3'b000, 1'b0, 32'h203, 32'd0, 32'd0, 32'h20, 32'h100, 4'd4, 32'h104, 1'b1, 32'h202};
    st[4] = '{OP_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'h40, 32'h100, 4'd5, 32'h104, 1'b1, 32'h140};
    st[5] = '{OP_BRANCH, 3'b001, 1'b0, 32'd1, 32'd2, 32'd0, 32'h20, 32'h100, 4'd6, 32'd0, 1'b1, 32'h120};
    st[6] = '{OP_BRANCH, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h20, 32'h100, 4'd7, 32'd0, 1'b0, 32'h104};
    st[7] = '{OP_BRANCH, 3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 32'h20, 32'h100, 4'd8, 32'd0, 1'b0, 32'h104};
    st[8] = '{7'b0000000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd9, 32'h20, 32'h100, 4'd9, 32'd0, 1'b0, 32'h104};
    n = 9;
    cdb_grant = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        n_chk++;
        if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
          n_fail++;
          $display("FAIL branch_%0d: req=%b head=%h expected %h", i - 1, cdb_req, head_obs, sb[0]);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (i < n) begin
        set_issue(st[i]);
        push_exp(st[i]);
      end else begin
        exe_valid = 1'b0;
      end
      @(negedge clk);
    end
    cdb_grant = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_drain: req=%b expected 0", cdb_req);
    end
  endtask

  task automatic test_rollback();
    cdb_grant = 1'b0;
    set_issue(mk_add(4'd1, 32'd1, 32'd1, 32'd2));
    @(negedge clk);
    set_issue(mk_add(4'd2, 32'd2, 32'd2, 32'd4));
    @(negedge clk);
    n_chk++;
    if (cdb_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_prefill: req=%b expected 1", cdb_req);
    end
    set_issue(mk_add(4'd3, 32'd3, 32'd3, 32'd6));
    rollback  = 1'b1;
    cdb_grant = 1'b1;
    #1;
    n_chk++;
    if (alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_ready: got %b expected 0", alu_ready);
    end
    @(negedge clk);
    rollback  = 1'b0;
    exe_valid = 1'b0;
    cdb_grant = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_flush: req=%b expected 0", cdb_req);
    end
    st[0] = mk_add(4'd5, 32'd10, 32'd20, 32'd30);
    st[1] = mk_add(4'd6, 32'hFFFFFFFF, 32'd2, 32'd1);
    for (int i = 0; i < 2; i++) begin
      set_issue(st[i]);
      push_exp(st[i]);
      #1;
      n_chk++;
      if (alu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rb_refill_%0d: ready=%b expected 1", i, alu_ready);
      end
      @(negedge clk);
    end
    exe_valid = 1'b0;
    #1;
    n_chk++;
    if (alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_refull: ready=%b expected 0", alu_ready);
    end
    cdb_grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
        n_fail++;
        $display("FAIL rb_drain_%0d: req=%b head=%h expected %h", i, cdb_req, head_obs, sb[0]);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge clk);
    end
    cdb_grant = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_empty: req=%b expected 0", cdb_req);
    end
  endtask

  task automatic test_stall();
    cdb_grant = 1'b0;
    st[0] = mk_add(4'd7, 32'd100, 32'd23, 32'd123);
    set_issue(st[0]);
    push_exp(st[0]);
    @(negedge clk);
    rdy       = 1'b0;
    cdb_grant = 1'b1;
    set_issue(mk_add(4'd8, 32'd1, 32'd1, 32'd2));
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (alu_ready !== 1'b0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: ready=%b req=%b head=%h expected 0 1 %h", i, alu_ready, cdb_req, head_obs, sb[0]);
      end
      @(negedge clk);
    end
    rdy       = 1'b1;
    exe_valid = 1'b0;
    n_chk++;
    if (sb.size() == 0 || cdb_req !== 1'b1 || head_obs !== sb[0]) begin
      n_fail++;
      $display("FAIL stall_resume: req=%b head=%h expected %h", cdb_req, head_obs, sb[0]);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    cdb_grant = 1'b0;
    n_chk++;
    if (cdb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_issue: req=%b tag=%0d expected req=0", cdb_req, alu_rob_id);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_branches();
    test_rollback();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Consumer end of the reservation-station issue interface.
- Accepts one ready RV32I integer/branch/jump instruction per cycle and computes the result and branch resolution.
- Buffers results in a small in-order FIFO and broadcasts them on the common data bus (CDB) under a request/grant handshake.
- Broadcast results go to the ROB, RS and LSB.
- Back-pressures the RS via `alu_ready`.

Parameters:
- `DATA_W`, 32, operand/result/PC width
- `ROB_ID_W`, 4, ROB tag width
- `DEPTH`, 2, result FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `rdy`  in  1  global enable; low freezes all state
- `rollback`  in  1  mispredict flush
- `exe_valid`  in  1  issue request from RS
- `exe_opcode`  in  7  RV32I opcode
- `exe_func3`  in  3  funct3
- `exe_func1`  in  1  inst[30]
- `exe_data1`  in  DATA_W  rs1 value
- `exe_data2`  in  DATA_W  rs2 value
- `exe_imm`  in  DATA_W  sign-extended immediate
- `exe_off`  in  DATA_W  branch/jump offset
- `exe_pc`  in  DATA_W  instruction PC
- `exe_rob_target`  in  ROB_ID_W  destination ROB tag
- `alu_ready`  out  1  can accept issue this cycle
- `cdb_req`  out  1  FIFO head valid, requesting CDB
- `cdb_grant`  in  1  arbiter grants CDB to this unit
- `alu_rob_id`  out  ROB_ID_W  head tag
- `alu_data`  out  DATA_W  head result (rd value)
- `alu_jump`  out  1  head: control transfer taken
- `alu_target_pc`  out  DATA_W  head: next PC

Behaviour:
- Async reset clears the FIFO pointers and count to 0.
  - `cdb_req=0`, `alu_rob_id=0`, `alu_data=0`, `alu_jump=0`, `alu_target_pc=0`.
  - `alu_ready` is 0 while `rst` is high.
- `alu_ready = rdy && !rollback && count<DEPTH`. It is combinational and has no same-cycle pass-through when full.
- Issue is accepted at a rising edge when `exe_valid && alu_ready`.
  - The result is computed combinationally from the `exe_*` inputs and written into the FIFO tail at that edge.
  - `exe_valid` while `!alu_ready` is ignored (dropped). The RS must gate issue on `alu_ready`.
- Latency: accept at edge N → `cdb_req=1` with head fields valid from edge N (visible in cycle N+1).
- Pop occurs at an edge with `cdb_req && cdb_grant && rdy && !rollback`. Results leave strictly in acceptance order.
- Simultaneous push and pop: count is unchanged. At `DEPTH=2` with count 2, no push is possible (`alu_ready=0`).
- Pointers wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.
- `cdb_grant` while `cdb_req=0`: no effect.
- Head output fields are undefined-but-stable when `cdb_req=0`. This implementation drives the storage at the read pointer.
- `rollback` (synchronous, priority over all but `rst`):
  - Empties the FIFO: pointers and count go to 0.
  - Same-cycle issue and grant are discarded.
- `rdy=0`: no push, no pop, state held.
- Results by opcode (`alu_jump=0` and `alu_target_pc=pc+4` unless stated):
  - LUI 0110111: data=imm
  - AUIPC 0010111: data=pc+imm
  - OP-IMM 0010011: data = op(data1, imm), with op selected by func3.
    - Shift amount is `imm[4:0]`.
    - SRAI when func3=101 and func1=1, else SRLI.
    - No SUB variant.
  - OP 0110011: data = op(data1, data2).
    - SUB when func3=000 and func1=1.
    - SRA when func3=101 and func1=1.
    - Shift amount is `data2[4:0]`.
  - func3 encodings: ADD 000, SLL 001, SLT 010 (signed), SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - JAL 1101111: data=pc+4, jump=1, target=pc+off
  - JALR 1100111: data=pc+4, jump=1, target=(data1+imm)&~1
  - BRANCH 1100011: data=0.
    - cond by func3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
    - jump=cond; target = cond ? pc+off : pc+4.
    - Invalid func3 gives cond=0.
  - Any other opcode: data=0, jump=0, target=pc+4. Still broadcast so the ROB entry retires.
- All arithmetic is modulo 2^DATA_W.

Test Plan:
1. Reset mid-operation: two results queued, assert `rst` asynchronously → `cdb_req=0` and all outputs 0 immediately. After release, `alu_ready=1`.
2. ADD then SUB, grant held high:
   - ADD: data1=5, data2=7, tag 3 → 1 cycle later `alu_rob_id=3`, `alu_data=12`.
   - SUB (func1=1): data1=5, data2=7 → `alu_data=0xFFFFFFFE`.
   - SRAI: imm=0x404 (func1=1), data1=0x80000000 → `alu_data=0xF8000000`.
3. Back-pressure:
   - With `cdb_grant=0`, issue 3 back-to-back → `alu_ready` falls after the 2nd accept and the 3rd is dropped.
   - Grant for 2 cycles → tags popped in order; `alu_ready` returns after the first pop.
   - A simultaneous push/pop at count 1 keeps count 1.
4. Branches/jumps, pc=0x100:
   - BLT with data1=-1, data2=1, off=0x20 → jump=1, target=0x120.
   - BGEU with the same operands → jump=1, target=0x120.
   - BEQ with unequal operands → jump=0, target=0x104.
   - JALR with data1=0x203, imm=0 → data=0x104, target=0x202.
5. Rollback: two entries queued plus `exe_valid` and `cdb_grant` high in the same cycle as `rollback` → next cycle `cdb_req=0`, count 0, nothing broadcast.
6. `rdy=0` for 3 cycles with a queued entry and grant high → entry still presented afterwards, no new issue accepted while `rdy=0`.
